// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types for the I2C transaction arbiter: byte-engine
//                command codes, controller FSM states and sequence phases.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   // Command codes understood by the byte engine
   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2,
      OP_STOP  = 2'd3
   } cmd_op_e;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_CMD  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Position within the START / address / data / STOP sequence
   typedef enum logic [1:0] {
      PH_START = 2'd0,
      PH_ADDR  = 2'd1,
      PH_DATA  = 2'd2,
      PH_STOP  = 2'd3
   } phase_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request found searching upward from (last + 1) mod N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int  N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt
);

   // Pick the asserted request with the smallest wrapped distance past 'last'
   always_comb begin
      int w_best;
      int w_dist;
      w_best = N;
      w_dist = 0;
      gnt    = '0;
      for (int i = 0; i < N; i++) begin
         w_dist = (i - int'(last) - 1 + 2 * N) % N;
         if (req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            gnt    = '0;
            gnt[i] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Shares one I2C byte engine among NUM_REQ requesters. Each
//                granted transaction runs START, address byte, up to MAX_LEN
//                data bytes and STOP, with NACK and response-timeout handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int  NUM_REQ        = 2,
   parameter int  MAX_LEN        = 4,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int LEN_W          = $clog2(MAX_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_rw,
   input  logic [NUM_REQ*7-1:0]     req_addr,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic [NUM_REQ*8-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       wr_pop,
   output logic [7:0]               rd_data,
   output logic [NUM_REQ-1:0]       rd_valid,
   output logic [NUM_REQ-1:0]       done,
   output logic                     err,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [1:0]               cmd_op,
   output logic [7:0]               cmd_data,
   output logic                     cmd_last,
   input  logic                     rsp_valid,
   input  logic [7:0]               rsp_data,
   input  logic                     rsp_nack
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
   localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e               r_state, w_state_nxt;
   phase_e               r_phase, w_phase_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [IDX_W-1:0]     r_last,  w_last_nxt;
   logic                 r_rw,    w_rw_nxt;
   logic [6:0]           r_addr,  w_addr_nxt;
   logic [LEN_W-1:0]     r_len,   w_len_nxt;
   logic [LEN_W-1:0]     r_cnt,   w_cnt_nxt;
   logic [TMO_W-1:0]     r_tmo,   w_tmo_nxt;
   logic                 r_err,   w_err_nxt;
   logic [NUM_REQ-1:0]   r_rd_valid;
   logic [7:0]           r_rd_data;

   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic                 w_sel_rw;
   logic [6:0]           w_sel_addr;
   logic [LEN_W-1:0]     w_sel_len;
   logic [7:0]           w_own_wdata;
   logic                 w_final;
   logic                 w_rd_capture;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req  (req_valid),
      .last (r_last),
      .gnt  (w_arb_gnt)
   );

   // Descriptor of the arbitration winner and the current owner's write byte
   always_comb begin
      w_arb_idx   = '0;
      w_sel_rw    = 1'b0;
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_own_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_arb_gnt[i]) begin
            w_arb_idx  = IDX_W'(i);
            w_sel_rw   = req_rw[i];
            w_sel_addr = req_addr[i*7 +: 7];
            w_sel_len  = req_len[i*LEN_W +: LEN_W];
         end
         if (r_grant[i]) begin
            w_own_wdata = req_wdata[i*8 +: 8];
         end
      end
   end

   assign w_final      = ((r_cnt + LEN_W'(1)) == r_len);
   assign w_rd_capture = (r_state == ST_WAIT) && rsp_valid && (r_phase == PH_DATA) && r_rw;

   // Next-state, command and handshake outputs of the transaction sequencer
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_rw_nxt    = r_rw;
      w_addr_nxt  = r_addr;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_err_nxt   = r_err;
      cmd_valid   = 1'b0;
      cmd_op      = OP_START;
      cmd_data    = '0;
      cmd_last    = 1'b0;
      wr_pop      = '0;
      done        = '0;
      err         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (|req_valid) w_state_nxt = ST_ARB;
         end

         ST_ARB: begin
            if (|w_arb_gnt) begin
               w_grant_nxt = w_arb_gnt;
               w_last_nxt  = w_arb_idx;
               w_rw_nxt    = w_sel_rw;
               w_addr_nxt  = w_sel_addr;
               w_len_nxt   = (w_sel_len > c_max_len) ? c_max_len : w_sel_len;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_phase_nxt = PH_START;
               w_state_nxt = ST_CMD;
            end else begin
               // Request withdrawn before it could be granted
               w_state_nxt = ST_IDLE;
            end
         end

         ST_CMD: begin
            cmd_valid = 1'b1;
            case (r_phase)
               PH_START: cmd_op = OP_START;
               PH_ADDR: begin
                  cmd_op   = OP_WRITE;
                  cmd_data = {r_addr, r_rw};
               end
               PH_DATA: begin
                  if (r_rw) begin
                     cmd_op   = OP_READ;
                     cmd_last = w_final;
                  end else begin
                     cmd_op   = OP_WRITE;
                     cmd_data = w_own_wdata;
                  end
               end
               default: cmd_op = OP_STOP;
            endcase
            if (cmd_ready) begin
               w_tmo_nxt   = '0;
               w_state_nxt = ST_WAIT;
               if ((r_phase == PH_DATA) && !r_rw) wr_pop = r_grant;
            end
         end

         ST_WAIT: begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
            if (rsp_valid) begin
               w_state_nxt = ST_CMD;
               case (r_phase)
                  PH_START: w_phase_nxt = PH_ADDR;
                  PH_ADDR: begin
                     if (rsp_nack) begin
                        w_err_nxt   = 1'b1;
                        w_phase_nxt = PH_STOP;
                     end else if (r_len == '0) begin
                        w_phase_nxt = PH_STOP;
                     end else begin
                        w_phase_nxt = PH_DATA;
                     end
                  end
                  PH_DATA: begin
                     // A NACK only matters on write data; reads ignore it
                     if (!r_rw && rsp_nack) begin
                        w_err_nxt   = 1'b1;
                        w_phase_nxt = PH_STOP;
                     end else begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                        if (w_final) w_phase_nxt = PH_STOP;
                     end
                  end
                  default: w_state_nxt = ST_DONE;
               endcase
            end else if (r_tmo == c_tmo_last) begin
               w_err_nxt = 1'b1;
               if (r_phase == PH_STOP) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_phase_nxt = PH_STOP;
                  w_state_nxt = ST_CMD;
               end
            end
         end

         ST_DONE: begin
            done        = r_grant;
            err         = r_err;
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and transaction-context registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_phase <= PH_START;
         r_grant <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_tmo   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_rw    <= w_rw_nxt;
         r_addr  <= w_addr_nxt;
         r_len   <= w_len_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tmo   <= w_tmo_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Read bytes are registered and qualified one cycle after the response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= '0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= w_rd_capture ? r_grant : '0;
         if (w_rd_capture) r_rd_data <= rsp_data;
      end
   end

   assign grant    = r_grant;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_txn_arbiter
//  Description : Directed table-driven bench for i2c_txn_arbiter with a
//                scripted byte-engine responder and requester write feed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

   localparam int NR  = 2;
   localparam int ML  = 4;
   localparam int TMO = 16;
   localparam int LW  = $clog2(ML + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid, req_rw;
   logic [NR*7-1:0] req_addr;
   logic [NR*LW-1:0] req_len;
   logic [NR*8-1:0] req_wdata;
   logic [NR-1:0]   grant, wr_pop, rd_valid, done;
   logic [7:0]      rd_data, cmd_data, rsp_data;
   logic            err, cmd_valid, cmd_ready, cmd_last, rsp_valid, rsp_nack;
   logic [1:0]      cmd_op;

   i2c_txn_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .grant(grant), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .err(err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               id;
      logic             rw;
      logic [6:0]       addr;
      int               len;
      logic [3:0][7:0]  wb;
      int               nack_at;
      int               hold_at;
      int               n_ops;
      logic [7:0][10:0] ops;
      int               n_pops;
      int               n_rd;
      logic [3:0][7:0]  rd;
      logic             err;
   } vec_t;

   vec_t vt[10];

   int total = 0, bad = 0;
   int cyc = 0, n_cmd = 0, cur_cmd = 0, pend = 0, nack_at = -1, hold_at = -1;
   int cur_id = 0, widx = 0, n_pops = 0, n_done = 0;
   logic [3:0][7:0] cur_wb;
   logic [10:0] op_log[$];
   logic [9:0]  rd_log[$];
   int          acc_t[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] o(input logic [1:0] op, input logic [7:0] d, input logic l);
      return {op, d, l};
   endfunction

   task automatic set_in(input int i, input int id, input logic rw, input logic [6:0] a,
                         input int len, input logic [31:0] wb, input int nk, input int hd,
                         input int pops, input logic e);
      vt[i].id = id; vt[i].rw = rw; vt[i].addr = a; vt[i].len = len; vt[i].wb = wb;
      vt[i].nack_at = nk; vt[i].hold_at = hd; vt[i].n_pops = pops; vt[i].err = e;
      vt[i].n_ops = 0; vt[i].ops = '0; vt[i].n_rd = 0; vt[i].rd = '0;
   endtask

   task automatic add_op(input int i, input logic [10:0] v);
      vt[i].ops[vt[i].n_ops] = v;
      vt[i].n_ops++;
   endtask

   task automatic add_rd(input int i, input logic [7:0] d);
      vt[i].rd[vt[i].n_rd] = d;
      vt[i].n_rd++;
   endtask

   // Byte-engine model, command logger and requester write-byte feed
   initial forever begin
      @(negedge clk);
      cyc++;
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            rsp_valid = 1'b1;
            rsp_nack  = (cur_cmd == nack_at);
            rsp_data  = 8'(8'h11 * (cur_cmd - 1));
         end
      end
      if (cmd_valid && cmd_ready) begin
         op_log.push_back({cmd_op, cmd_data, cmd_last});
         acc_t.push_back(cyc);
         cur_cmd = n_cmd;
         n_cmd++;
         pend = (cur_cmd == hold_at) ? 0 : 2;
      end
      if (wr_pop != '0) begin
         n_pops++;
         if (wr_pop[cur_id]) begin
            widx++;
            req_wdata[cur_id*8 +: 8] = (widx < 4) ? cur_wb[widx] : 8'h00;
         end
      end
      if (rd_valid != '0) rd_log.push_back({rd_valid, rd_data});
      if (done != '0) n_done++;
   end

   task automatic run_vec(input int i);
      vec_t v;
      int k;
      logic [1:0] d;
      logic e;
      logic [31:0] a;
      v = vt[i];
      op_log.delete(); rd_log.delete(); acc_t.delete();
      n_cmd = 0; n_pops = 0; widx = 0; pend = 0;
      nack_at = v.nack_at; hold_at = v.hold_at; cur_id = v.id; cur_wb = v.wb;
      req_rw[v.id] = v.rw;
      req_addr[v.id*7 +: 7] = v.addr;
      req_len[v.id*LW +: LW] = LW'(v.len);
      req_wdata[v.id*8 +: 8] = v.wb[0];
      req_valid[v.id] = 1'b1;
      k = 0; d = '0; e = 1'b0;
      while (k < 300) begin
         @(negedge clk); #1;
         k++;
         if (done != '0) begin
            d = done; e = err;
            break;
         end
      end
      req_valid[v.id] = 1'b0;
      chk($sformatf("v%0d_done", i), 32'(d), 32'(1 << v.id));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(v.err));
      chk($sformatf("v%0d_nops", i), op_log.size(), v.n_ops);
      for (int j = 0; j < v.n_ops; j++) begin
         a = (j < op_log.size()) ? 32'(op_log[j]) : 32'hFFFF_FFFF;
         chk($sformatf("v%0d_op%0d", i, j), a, 32'(v.ops[j]));
      end
      chk($sformatf("v%0d_pops", i), n_pops, v.n_pops);
      chk($sformatf("v%0d_nrd", i), rd_log.size(), v.n_rd);
      for (int j = 0; j < v.n_rd; j++) begin
         a = (j < rd_log.size()) ? 32'(rd_log[j]) : 32'hFFFF_FFFF;
         chk($sformatf("v%0d_rd%0d", i, j), a, {22'd0, 2'(1 << v.id), v.rd[j]});
      end
      if (v.hold_at == 2) begin
         a = (acc_t.size() > 3) ? 32'(acc_t[3] - acc_t[2]) : 32'hFFFF_FFFF;
         chk($sformatf("v%0d_tmo_gap", i), a, TMO + 1);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic arb_round(input string nm, input logic [1:0] exp);
      int k;
      logic [1:0] g;
      g = '0; k = 0;
      while (g == '0 && k < 100) begin
         @(negedge clk); #1;
         g = grant; k++;
      end
      chk(nm, 32'(g), 32'(exp));
      k = 0;
      while (done == '0 && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      chk({nm, "_done"}, 32'(done), 32'(exp));
      req_valid = req_valid & ~g;
   endtask

   initial begin
      int k, snap_cmd, snap_done;
      rst = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_len = '0; req_wdata = '0;
      cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      cur_wb = '0;

      // Expected vectors
      set_in(0, 0, 1'b0, 7'h2A, 1, 32'h0000_0074, -1, -1, 1, 1'b0);
      add_op(0, o(2'd0, 8'h00, 0)); add_op(0, o(2'd1, 8'h54, 0));
      add_op(0, o(2'd1, 8'h74, 0)); add_op(0, o(2'd3, 8'h00, 0));
      set_in(1, 1, 1'b1, 7'h2A, 2, 32'h0, -1, -1, 0, 1'b0);
      add_op(1, o(2'd0, 8'h00, 0)); add_op(1, o(2'd1, 8'h55, 0)); add_op(1, o(2'd2, 8'h00, 0));
      add_op(1, o(2'd2, 8'h00, 1)); add_op(1, o(2'd3, 8'h00, 0));
      add_rd(1, 8'h11); add_rd(1, 8'h22);
      set_in(2, 0, 1'b0, 7'h2A, 3, 32'h00C3_B2A1, 1, -1, 0, 1'b1);
      add_op(2, o(2'd0, 8'h00, 0)); add_op(2, o(2'd1, 8'h54, 0)); add_op(2, o(2'd3, 8'h00, 0));
      set_in(3, 1, 1'b0, 7'h10, 3, 32'h00A3_A2A1, 2, -1, 1, 1'b1);
      add_op(3, o(2'd0, 8'h00, 0)); add_op(3, o(2'd1, 8'h20, 0));
      add_op(3, o(2'd1, 8'hA1, 0)); add_op(3, o(2'd3, 8'h00, 0));
      set_in(4, 0, 1'b1, 7'h7F, 0, 32'h0, -1, -1, 0, 1'b0);
      add_op(4, o(2'd0, 8'h00, 0)); add_op(4, o(2'd1, 8'hFF, 0)); add_op(4, o(2'd3, 8'h00, 0));
      set_in(5, 0, 1'b0, 7'h05, 7, 32'hC3C2_C1C0, -1, -1, 4, 1'b0);
      add_op(5, o(2'd0, 8'h00, 0)); add_op(5, o(2'd1, 8'h0A, 0)); add_op(5, o(2'd1, 8'hC0, 0));
      add_op(5, o(2'd1, 8'hC1, 0)); add_op(5, o(2'd1, 8'hC2, 0)); add_op(5, o(2'd1, 8'hC3, 0));
      add_op(5, o(2'd3, 8'h00, 0));
      set_in(6, 1, 1'b1, 7'h33, 1, 32'h0, 2, -1, 0, 1'b0);
      add_op(6, o(2'd0, 8'h00, 0)); add_op(6, o(2'd1, 8'h67, 0));
      add_op(6, o(2'd2, 8'h00, 1)); add_op(6, o(2'd3, 8'h00, 0));
      add_rd(6, 8'h11);
      set_in(7, 0, 1'b0, 7'h01, 0, 32'h0, 2, -1, 0, 1'b0);
      add_op(7, o(2'd0, 8'h00, 0)); add_op(7, o(2'd1, 8'h02, 0)); add_op(7, o(2'd3, 8'h00, 0));
      set_in(8, 0, 1'b0, 7'h2A, 2, 32'h0000_7574, -1, 2, 1, 1'b1);
      add_op(8, o(2'd0, 8'h00, 0)); add_op(8, o(2'd1, 8'h54, 0));
      add_op(8, o(2'd1, 8'h74, 0)); add_op(8, o(2'd3, 8'h00, 0));
      set_in(9, 1, 1'b0, 7'h2A, 1, 32'h0000_0074, -1, 3, 1, 1'b1);
      add_op(9, o(2'd0, 8'h00, 0)); add_op(9, o(2'd1, 8'h54, 0));
      add_op(9, o(2'd1, 8'h74, 0)); add_op(9, o(2'd3, 8'h00, 0));

      // Reset state
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      chk("rst_outs", {3'd0, grant, cmd_valid, cmd_op, cmd_data, cmd_last, wr_pop,
                       rd_valid, rd_data, done, err}, 32'd0);

      // Round-robin: simultaneous requests after reset
      n_cmd = 0; nack_at = -1; hold_at = -1; cur_id = 0;
      req_rw = '0; req_len = '0; req_addr = {7'h02, 7'h01};
      req_valid = 2'b11;
      arb_round("rr_first", 2'b01);
      arb_round("rr_second", 2'b10);
      req_valid = 2'b11;
      arb_round("rr_third", 2'b01);
      arb_round("rr_fourth", 2'b10);
      repeat (2) @(negedge clk);

      // Table-driven transactions
      for (int i = 0; i < 10; i++) run_vec(i);

      // Reset while waiting on a response abandons the transaction silently
      op_log.delete(); n_cmd = 0; pend = 0; nack_at = -1; hold_at = 1; cur_id = 1;
      req_rw[1] = 1'b0; req_addr[7 +: 7] = 7'h2A; req_len[LW +: LW] = LW'(1);
      req_valid = 2'b10;
      k = 0;
      while (n_cmd < 2 && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      chk("rstw_reached_wait", n_cmd, 2);
      @(negedge clk); #1;
      rst = 1'b1; req_valid = '0;
      @(negedge clk); #1;
      rst = 1'b0;
      chk("rstw_outs", {3'd0, grant, cmd_valid, cmd_op, cmd_data, cmd_last, wr_pop,
                        rd_valid, rd_data, done, err}, 32'd0);
      snap_cmd = n_cmd; snap_done = n_done;
      repeat (5) @(negedge clk);
      chk("rstw_no_stop", n_cmd, snap_cmd);
      chk("rstw_no_done", n_done, snap_done);
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
